// File: rtl/fifo_pkg.sv
// Shared definitions for the dual-clock FIFO pointer logic: default depth and
// Gray-code helpers used by both the write-side and read-side controllers.
package fifo_pkg;

  localparam int FIFO_ADDRSIZE = 4;
  // Helpers work on a fixed wide vector; callers zero-extend narrower pointers.
  localparam int PTR_MAX = 16;

  function automatic logic [PTR_MAX-1:0] bin2gray(input logic [PTR_MAX-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PTR_MAX-1:0] gray2bin(input logic [PTR_MAX-1:0] g);
    logic [PTR_MAX-1:0] b;
    b[PTR_MAX-1] = g[PTR_MAX-1];
    for (int i = PTR_MAX - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Gray value the write pointer takes when it is exactly one lap ahead of g.
  function automatic logic [PTR_MAX-1:0] full_target(input logic [PTR_MAX-1:0] g,
                                                     input int w);
    return g ^ (PTR_MAX'(3) << (w - 2));
  endfunction

endpackage

// File: rtl/sync_r2w.sv
// Two-flop synchronizer for a Gray pointer crossing into the local clock domain.
module sync_r2w #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         srst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] s1_q, s1_d;
  logic [W-1:0] s2_q, s2_d;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/wptr_full_ctrl.sv
// Write-domain pointer, full/almost-full, fill level and sticky overflow
// status for the dual-clock FIFO.
module wptr_full_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE = FIFO_ADDRSIZE,
  parameter int AF_LEVEL = 14
) (
  input  logic                wclk,
  input  logic                wrst,
  input  logic                winc,
  input  logic                ovf_clr,
  input  logic [ADDRSIZE:0]   rptr,
  output logic                wen,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic                walmost_full,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                woverflow
);

  localparam int PW = ADDRSIZE + 1;

  logic [PW-1:0] wbin_q, wbin_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] wlevel_q, wlevel_d;
  logic          wfull_q, wfull_d;
  logic          walmost_full_q, walmost_full_d;
  logic          woverflow_q, woverflow_d;

  logic [PW-1:0]      wq2_rptr;
  logic [PW-1:0]      wq2_bin;
  logic               wen_c;
  logic [PTR_MAX-1:0] gray_ext;
  logic [PTR_MAX-1:0] wq2_bin_ext;
  logic [PTR_MAX-1:0] full_ext;

  sync_r2w #(.W(PW)) u_sync_r2w (
    .clk  (wclk),
    .srst (wrst),
    .d    (rptr),
    .q    (wq2_rptr)
  );

  always_comb begin
    // A write coinciding with reset is dropped, so reset never commits data.
    wen_c       = winc & ~wfull_q & ~wrst;
    wbin_d      = wbin_q + PW'(wen_c);
    gray_ext    = bin2gray({{(PTR_MAX-PW){1'b0}}, wbin_d});
    wptr_d      = gray_ext[PW-1:0];
    wq2_bin_ext = gray2bin({{(PTR_MAX-PW){1'b0}}, wq2_rptr});
    wq2_bin     = wq2_bin_ext[PW-1:0];
    full_ext    = full_target({{(PTR_MAX-PW){1'b0}}, wq2_rptr}, PW);
    wfull_d     = (wptr_d == full_ext[PW-1:0]);
    wlevel_d    = wbin_d - wq2_bin;
    walmost_full_d = (32'(wlevel_d) >= AF_LEVEL);
    woverflow_d    = (winc & wfull_q) | (woverflow_q & ~ovf_clr);
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      wbin_q         <= '0;
      wptr_q         <= '0;
      wlevel_q       <= '0;
      wfull_q        <= 1'b0;
      walmost_full_q <= 1'b0;
      woverflow_q    <= 1'b0;
    end else begin
      wbin_q         <= wbin_d;
      wptr_q         <= wptr_d;
      wlevel_q       <= wlevel_d;
      wfull_q        <= wfull_d;
      walmost_full_q <= walmost_full_d;
      woverflow_q    <= woverflow_d;
    end
  end

  assign wen          = wen_c;
  assign waddr        = wbin_q[ADDRSIZE-1:0];
  assign wptr         = wptr_q;
  assign wfull        = wfull_q;
  assign walmost_full = walmost_full_q;
  assign wlevel       = wlevel_q;
  assign woverflow    = woverflow_q;

endmodule

// File: doc/wptr_full_ctrl.md
# wptr_full_ctrl

Write-side pointer and full-flag controller for the dual-clock FIFO. It is the counterpart of the read-pointer/empty logic. It lives entirely in the write clock domain and synchronizes the read domain's Gray pointer internally. From that pointer it produces the memory write address and enable, the write-domain Gray pointer, and registered full, almost-full, fill-level and sticky-overflow status.

## Interface
- ADDRSIZE, 4, log2 of FIFO depth; depth = 2^ADDRSIZE.
- AF_LEVEL, 14, fill level at or above which walmost_full asserts; legal range 1..2^ADDRSIZE.
- wclk  in  1  write clock; all logic is on its rising edge.
- wrst  in  1  reset, synchronous and active-high; one clock, no other reset.
- winc  in  1  write request for this cycle.
- ovf_clr  in  1  clears woverflow.
- rptr  in  ADDRSIZE+1  read-domain Gray pointer, asynchronous to wclk.
- wen  out  1  memory write enable, combinational: winc & ~wfull.
- waddr  out  ADDRSIZE  memory write address, equal to wbin[ADDRSIZE-1:0].
- wptr  out  ADDRSIZE+1  registered write Gray pointer, sent to the read domain.
- wfull  out  1  registered full flag.
- walmost_full  out  1  registered almost-full flag.
- wlevel  out  ADDRSIZE+1  registered fill level, 0..2^ADDRSIZE.
- woverflow  out  1  sticky flag: a write was attempted while full.

## Operation
- Internal binary pointer wbin has width ADDRSIZE+1 and wraps modulo 2^(ADDRSIZE+1): 31 -> 0 when ADDRSIZE=4.
- wbinnext = wbin + wen.
- wgraynext = (wbinnext >> 1) ^ wbinnext.
- wbin and wptr load wbinnext and wgraynext every cycle.
- rptr passes through two flops into wq2_rptr.
- wq2_bin = Gray-to-binary of wq2_rptr.
- full_val = (wgraynext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]}).
- level_val = (wbinnext - wq2_bin) modulo 2^(ADDRSIZE+1). The result never exceeds 2^ADDRSIZE.
- Each cycle: wfull <= full_val, wlevel <= level_val, walmost_full <= (level_val >= AF_LEVEL).
- Overflow: winc & wfull sets woverflow on the next edge. The pointers do not advance and no memory write occurs (wen=0).
- ovf_clr clears woverflow. If set and clear occur in the same cycle, set wins.
- Reset (wrst=1 at an edge) drives all of the following to 0: wbin, wptr, both synchronizer stages, wfull, walmost_full, wlevel, woverflow.
- Reset mid-operation discards all state. No write is performed in the reset cycle, even if winc=1.

## Timing
- wen and waddr are combinational from winc, wfull and wbin in the same cycle.
- A write in cycle N updates wptr, wlevel and wfull at edge N+1.
- Writes to an empty FIFO: wfull rises on the edge that stores the 2^ADDRSIZE-th entry, so the next cycle already blocks writes.
- Reads are seen pessimistically. A change on rptr reaches wq2_rptr after 2 wclk edges and affects wfull, wlevel and walmost_full 1 edge later.
- wfull may therefore stay high up to 3 wclk cycles after a read. It must never be low while the FIFO is truly full.
- A write and the arrival of a synchronized read in the same cycle combine: level is unchanged and full is recomputed from both pointers.
- rptr must change by at most one Gray step per rclk. Multi-bit skew on rptr is not supported.

## Structure
- Shared package fifo_pkg holds:
  - default ADDRSIZE;
  - bin2gray and gray2bin functions parameterized on width;
  - the full-compare helper (invert the two MSBs of the Gray pointer).
- Sub-module sync_r2w: a two-flop synchronizer of width ADDRSIZE+1 with synchronous active-high reset, instantiated once. It is reused later for the read side's write-pointer sync.
- The top level holds the pointer registers, status registers and overflow logic.

## Test plan
All scenarios use ADDRSIZE=4 and AF_LEVEL=14.
- Reset, then 20 idle cycles with rptr=0 -> wptr=0, waddr=0, wfull=0, wlevel=0, walmost_full=0, woverflow=0.
- 16 back-to-back writes with rptr held at 0:
  - wlevel steps 1..16;
  - walmost_full rises after write 14;
  - wfull rises after write 16;
  - wptr ends at 5'b11000 (binary 16);
  - a 17th winc gives wen=0 and woverflow=1 on the next edge.
- From full, drive rptr=5'b00001 (one read) -> wfull falls on the 3rd wclk edge and wlevel=15; one write then refills, so wfull=1 and wlevel=16.
- Wrap: run 40 writes interleaved with matching rptr Gray steps -> waddr wraps 15 -> 0, wbin wraps 31 -> 0, and wfull never asserts falsely.
- Overflow control:
  - set and ovf_clr in the same cycle -> woverflow stays 1;
  - ovf_clr alone -> woverflow=0 next edge.
- Assert wrst for one cycle with wlevel=9 and winc=1 -> next cycle all outputs are 0 and no wen pulse occurs in the reset cycle.
